// File: rtl/fpu_issue_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_sched_if
// Brief    : Request, FPU-side and response signals of the FPU issue scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface fpu_issue_sched_if #(
    parameter int TAG_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic [3:0]       fpu_op;
    logic [31:0]      fpu_a;
    logic [31:0]      fpu_b;
    logic [31:0]      fpu_result;
    logic [31:0]      fpu_int_result;

    logic             rsp_valid;
    logic [TAG_W-1:0] rsp_tag;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic             busy;

    // Scheduler side.
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag,
        input  fpu_result, fpu_int_result,
        output req_ready, fpu_op, fpu_a, fpu_b,
        output rsp_valid, rsp_tag, rsp_data, rsp_err, busy
    );

    // Requester / FPU side.
    modport master (
        output req_valid, req_op, req_a, req_b, req_tag,
        output fpu_result, fpu_int_result,
        input  req_ready, fpu_op, fpu_a, fpu_b,
        input  rsp_valid, rsp_tag, rsp_data, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/fpu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : fpu_issue_sched
// Brief    : Single-issue scheduler in front of the multicycle FPU; reserves
//            each op's completion cycle so results never collide.
// Revision : 1.0 - initial release
// ============================================================================
module fpu_issue_sched #(
    parameter int TAG_W  = 5,
    parameter int WARMUP = 3
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fpu_issue_sched_if.slave bus
);
    localparam logic [3:0] OP_FADD  = 4'b0000;
    localparam logic [3:0] OP_FSUB  = 4'b0001;
    localparam logic [3:0] OP_FMUL  = 4'b0010;
    localparam logic [3:0] OP_FDIV  = 4'b0011;
    localparam logic [3:0] OP_FSQRT = 4'b0100;
    localparam logic [3:0] OP_FLOOR = 4'b0101;
    localparam logic [3:0] OP_FTOI  = 4'b0110;
    localparam logic [3:0] OP_ITOF  = 4'b0111;
    localparam logic [3:0] OP_FEQ   = 4'b1000;
    localparam logic [3:0] OP_FLESS = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    localparam int               CNT_W     = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CNT_W-1:0] WARM_INIT = CNT_W'(WARMUP);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             is_int;
        logic             err;
    } slot_t;

    slot_t      [3:0] slot_q, slot_d;
    logic [CNT_W-1:0] warm_cnt_q, warm_cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic [31:0]      rsp_data_q, rsp_data_d;

    logic [1:0]       w_lat;
    logic             w_is_int;
    logic             w_illegal;
    logic             w_warm;
    logic             w_fire;
    slot_t            w_new;
    slot_t            w_cmp;

    always_comb begin
        w_lat     = 2'd1;
        w_is_int  = 1'b0;
        w_illegal = 1'b0;
        case (bus.req_op)
            OP_FEQ, OP_FLESS: begin
                w_lat    = 2'd0;
                w_is_int = 1'b1;
            end
            OP_FTOI:  w_is_int = 1'b1;
            OP_FADD, OP_FSUB, OP_FMUL, OP_FLOOR, OP_ITOF: w_lat = 2'd1;
            OP_FSQRT: w_lat = 2'd2;
            OP_FDIV:  w_lat = 2'd3;
            default: begin
                w_lat     = 2'd0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Ready may only depend on the offered opcode, never on req_valid.
    always_comb begin
        w_warm        = (warm_cnt_q != '0);
        bus.req_ready = ~rst & ~w_warm & ~slot_q[w_lat].valid;
        w_fire        = bus.req_valid & bus.req_ready;

        bus.fpu_op = OP_NOP;
        bus.fpu_a  = 32'd0;
        bus.fpu_b  = 32'd0;
        if (w_fire && !w_illegal) begin
            bus.fpu_op = bus.req_op;
            bus.fpu_a  = bus.req_a;
            bus.fpu_b  = bus.req_b;
        end

        w_new = '{valid: 1'b1, tag: bus.req_tag, is_int: w_is_int, err: w_illegal};

        slot_d[0] = slot_q[1];
        slot_d[1] = slot_q[2];
        slot_d[2] = slot_q[3];
        slot_d[3] = '0;
        if (w_fire && (w_lat != 2'd0)) begin
            slot_d[w_lat - 2'd1] = w_new;
        end

        // The ready rule guarantees slot 0 is empty whenever a zero-latency op fires.
        w_cmp = slot_q[0];
        if (w_fire && (w_lat == 2'd0)) begin
            w_cmp = w_new;
        end

        rsp_valid_d = w_cmp.valid;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        if (w_cmp.valid) begin
            rsp_tag_d  = w_cmp.tag;
            rsp_err_d  = w_cmp.err;
            rsp_data_d = w_cmp.err    ? 32'd0 :
                         w_cmp.is_int ? bus.fpu_int_result : bus.fpu_result;
        end

        warm_cnt_d = w_warm ? (warm_cnt_q - CNT_W'(1)) : warm_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q      <= '0;
            warm_cnt_q  <= WARM_INIT;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
            rsp_data_q  <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            warm_cnt_q  <= warm_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = rst | w_warm | slot_q[0].valid | slot_q[1].valid |
                           slot_q[2].valid | slot_q[3].valid;
endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_issue_sched
// Brief    : Directed self-checking bench for fpu_issue_sched with a small
//            latency-accurate FPU model driving the result buses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_issue_sched;
    localparam logic [3:0] OP_FADD  = 4'b0000;
    localparam logic [3:0] OP_FMUL  = 4'b0010;
    localparam logic [3:0] OP_FDIV  = 4'b0011;
    localparam logic [3:0] OP_FSQRT = 4'b0100;
    localparam logic [3:0] OP_FTOI  = 4'b0110;
    localparam logic [3:0] OP_FEQ   = 4'b1000;
    localparam logic [3:0] OP_FLESS = 4'b1001;
    localparam logic [3:0] OP_NOP   = 4'b1111;
    localparam logic [31:0] GARBAGE = 32'h0BAD_F00D;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    fpu_issue_sched_if #(.TAG_W(5)) bus ();

    fpu_issue_sched #(.TAG_W(5), .WARMUP(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Hand-computed results for the operand pairs used below.
    function automatic logic [31:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == OP_FADD  && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (op == OP_FDIV  && a == 32'h40C0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (op == OP_FMUL  && a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4080_0000;
        if (op == OP_FSQRT && a == 32'h4080_0000)                       return 32'h4000_0000;
        if (op == OP_FTOI  && a == 32'h40A0_0000)                       return 32'h0000_0005;
        if (op == OP_FLESS && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h0000_0001;
        return 32'hDEAD_0000 | {28'd0, op};
    endfunction

    function automatic int model_lat(input logic [3:0] op);
        if (op == OP_FEQ || op == OP_FLESS) return 0;
        if (op == OP_FSQRT) return 2;
        if (op == OP_FDIV)  return 3;
        return 1;
    endfunction

    // FPU model: result appears L cycles after the op is presented; the
    // unused result bus carries garbage so a wrong source select shows up.
    logic [31:0] pend_val [4];
    logic        pend_int [4];
    logic        pend_v   [4];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            pend_val[k] <= pend_val[k+1];
            pend_int[k] <= pend_int[k+1];
            pend_v[k]   <= pend_v[k+1];
        end
        pend_v[3] <= 1'b0;
        if (bus.fpu_op != OP_NOP && model_lat(bus.fpu_op) != 0) begin
            pend_val[model_lat(bus.fpu_op)-1] <= calc(bus.fpu_op, bus.fpu_a, bus.fpu_b);
            pend_int[model_lat(bus.fpu_op)-1] <= (bus.fpu_op == OP_FTOI);
            pend_v[model_lat(bus.fpu_op)-1]   <= 1'b1;
        end
    end

    always_comb begin
        bus.fpu_result     = GARBAGE;
        bus.fpu_int_result = GARBAGE;
        if (bus.fpu_op == OP_FEQ || bus.fpu_op == OP_FLESS) begin
            bus.fpu_int_result = calc(bus.fpu_op, bus.fpu_a, bus.fpu_b);
        end else if (pend_v[0] === 1'b1) begin
            if (pend_int[0]) bus.fpu_int_result = pend_val[0];
            else             bus.fpu_result     = pend_val[0];
        end
    end

    // Moves to the next negedge, applies inputs, then settles before checks.
    task automatic set_req(input logic v, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_tag   = tag;
        #1;
    endtask

    task automatic test_reset();
        set_req(1'b1, OP_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd1);
        tests_run++; if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
        tests_run++; if (bus.fpu_op !== OP_NOP) begin tests_failed++; $display("FAIL rst_fpu_op: got %b want 1111", bus.fpu_op); end
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL rst_busy: got %b want 1", bus.busy); end
        tests_run++; if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_data, bus.rsp_err} !== 39'd0) begin
            tests_failed++; $display("FAIL rst_rsp: got v=%b tag=%0d data=%h err=%b want all 0",
                                     bus.rsp_valid, bus.rsp_tag, bus.rsp_data, bus.rsp_err); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) set_req(i < 3, OP_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd1);
            else if (0) ;
            tests_run++; if (bus.req_ready !== (i == 3)) begin tests_failed++; $display("FAIL warm_ready[%0d]: got %b want %b", i, bus.req_ready, i == 3); end
            tests_run++; if (bus.fpu_op !== OP_NOP) begin tests_failed++; $display("FAIL warm_fpu_op[%0d]: got %b want 1111", i, bus.fpu_op); end
            tests_run++; if (bus.busy !== (i != 3)) begin tests_failed++; $display("FAIL warm_busy[%0d]: got %b want %b", i, bus.busy, i != 3); end
        end
    endtask

    task automatic test_fadd();
        set_req(1'b1, OP_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd3);
        tests_run++; if (bus.req_ready !== 1'b1 || bus.fpu_op !== OP_FADD || bus.fpu_a !== 32'h3F80_0000 || bus.fpu_b !== 32'h4000_0000) begin
            tests_failed++; $display("FAIL fadd_issue: got rdy=%b op=%b a=%h b=%h want 1 0000 3f800000 40000000",
                                     bus.req_ready, bus.fpu_op, bus.fpu_a, bus.fpu_b); end
        set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
        tests_run++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin
            tests_failed++; $display("FAIL fadd_t1: got v=%b busy=%b want v=0 busy=1", bus.rsp_valid, bus.busy); end
        set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
        tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 5'd3 || bus.rsp_data !== 32'h4040_0000 || bus.rsp_err !== 1'b0) begin
            tests_failed++; $display("FAIL fadd_rsp: got v=%b tag=%0d data=%h err=%b want 1 3 40400000 0",
                                     bus.rsp_valid, bus.rsp_tag, bus.rsp_data, bus.rsp_err); end
        set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
        tests_run++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++; $display("FAIL fadd_pulse: got v=%b busy=%b want 0 0", bus.rsp_valid, bus.busy); end
    endtask

    task automatic test_back_to_back();
        set_req(1'b1, OP_FDIV, 32'h40C0_0000, 32'h4000_0000, 5'd1);
        tests_run++; if (bus.req_ready !== 1'b1 || bus.fpu_op !== OP_FDIV) begin
            tests_failed++; $display("FAIL b2b_fdiv_issue: got rdy=%b op=%b want 1 0011", bus.req_ready, bus.fpu_op); end
        set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
        set_req(1'b1, OP_FMUL, 32'h4000_0000, 32'h4000_0000, 5'd2);
        tests_run++; if (bus.req_ready !== 1'b0 || bus.fpu_op !== OP_NOP) begin
            tests_failed++; $display("FAIL b2b_fmul_stall: got rdy=%b op=%b want 0 1111", bus.req_ready, bus.fpu_op); end
        set_req(1'b1, OP_FMUL, 32'h4000_0000, 32'h4000_0000, 5'd2);
        tests_run++; if (bus.req_ready !== 1'b1 || bus.fpu_op !== OP_FMUL) begin
            tests_failed++; $display("FAIL b2b_fmul_fire: got rdy=%b op=%b want 1 0010", bus.req_ready, bus.fpu_op); end
        set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
        tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 5'd1 || bus.rsp_data !== 32'h4040_0000) begin
            tests_failed++; $display("FAIL b2b_rsp_fdiv: got v=%b tag=%0d data=%h want 1 1 40400000", bus.rsp_valid, bus.rsp_tag, bus.rsp_data); end
        set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
        tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 5'd2 || bus.rsp_data !== 32'h4080_0000) begin
            tests_failed++; $display("FAIL b2b_rsp_fmul: got v=%b tag=%0d data=%h want 1 2 40800000", bus.rsp_valid, bus.rsp_tag, bus.rsp_data); end
    endtask

    task automatic test_int_ops();
        set_req(1'b1, OP_FTOI, 32'h40A0_0000, 32'd0, 5'd4);
        tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL int_ftoi_ready: got %b want 1", bus.req_ready); end
        set_req(1'b1, OP_FLESS, 32'h3F80_0000, 32'h4000_0000, 5'd5);
        tests_run++; if (bus.req_ready !== 1'b0 || bus.fpu_op !== OP_NOP) begin
            tests_failed++; $display("FAIL int_fless_stall: got rdy=%b op=%b want 0 1111", bus.req_ready, bus.fpu_op); end
        set_req(1'b1, OP_FLESS, 32'h3F80_0000, 32'h4000_0000, 5'd5);
        tests_run++; if (bus.req_ready !== 1'b1 || bus.fpu_op !== OP_FLESS) begin
            tests_failed++; $display("FAIL int_fless_fire: got rdy=%b op=%b want 1 1001", bus.req_ready, bus.fpu_op); end
        tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 5'd4 || bus.rsp_data !== 32'h0000_0005) begin
            tests_failed++; $display("FAIL int_rsp_ftoi: got v=%b tag=%0d data=%h want 1 4 00000005", bus.rsp_valid, bus.rsp_tag, bus.rsp_data); end
        set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
        tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 5'd5 || bus.rsp_data !== 32'h0000_0001) begin
            tests_failed++; $display("FAIL int_rsp_fless: got v=%b tag=%0d data=%h want 1 5 00000001", bus.rsp_valid, bus.rsp_tag, bus.rsp_data); end
    endtask

    task automatic test_sqrt_then_add();
        set_req(1'b1, OP_FSQRT, 32'h4080_0000, 32'd0, 5'd7);
        tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL sqrt_ready: got %b want 1", bus.req_ready); end
        set_req(1'b1, OP_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd8);
        tests_run++; if (bus.req_ready !== 1'b0) begin tests_failed++; $display("FAIL sqrt_fadd_stall: got %b want 0", bus.req_ready); end
        set_req(1'b1, OP_FADD, 32'h3F80_0000, 32'h4000_0000, 5'd8);
        tests_run++; if (bus.req_ready !== 1'b1 || bus.fpu_op !== OP_FADD) begin
            tests_failed++; $display("FAIL sqrt_fadd_fire: got rdy=%b op=%b want 1 0000", bus.req_ready, bus.fpu_op); end
        set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
        tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 5'd7 || bus.rsp_data !== 32'h4000_0000) begin
            tests_failed++; $display("FAIL sqrt_rsp: got v=%b tag=%0d data=%h want 1 7 40000000", bus.rsp_valid, bus.rsp_tag, bus.rsp_data); end
        set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
        tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 5'd8 || bus.rsp_data !== 32'h4040_0000) begin
            tests_failed++; $display("FAIL sqrt_fadd_rsp: got v=%b tag=%0d data=%h want 1 8 40400000", bus.rsp_valid, bus.rsp_tag, bus.rsp_data); end
    endtask

    task automatic test_illegal();
        set_req(1'b1, 4'b1100, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9);
        tests_run++; if (bus.req_ready !== 1'b1 || bus.fpu_op !== OP_NOP || bus.fpu_a !== 32'd0 || bus.fpu_b !== 32'd0) begin
            tests_failed++; $display("FAIL illegal_issue: got rdy=%b op=%b a=%h b=%h want 1 1111 0 0",
                                     bus.req_ready, bus.fpu_op, bus.fpu_a, bus.fpu_b); end
        set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
        tests_run++; if (bus.rsp_valid !== 1'b1 || bus.rsp_tag !== 5'd9 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'd0) begin
            tests_failed++; $display("FAIL illegal_rsp: got v=%b tag=%0d err=%b data=%h want 1 9 1 0",
                                     bus.rsp_valid, bus.rsp_tag, bus.rsp_err, bus.rsp_data); end
    endtask

    task automatic test_reset_mid_op();
        set_req(1'b1, OP_FDIV, 32'h40C0_0000, 32'h4000_0000, 5'd10);
        tests_run++; if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_fire: got %b want 1", bus.req_ready); end
        set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
        rst = 1'b1;
        #1;
        tests_run++; if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.fpu_op !== OP_NOP || bus.rsp_valid !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_state: got busy=%b rdy=%b op=%b v=%b want 1 0 1111 0",
                                     bus.busy, bus.req_ready, bus.fpu_op, bus.rsp_valid); end
        set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_req(1'b0, OP_FADD, 32'd0, 32'd0, 5'd0);
            tests_run++; if (bus.rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL midrst_no_rsp[%0d]: got %b want 0", i, bus.rsp_valid); end
        end
        tests_run++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_idle: got busy=%b rdy=%b want 0 1", bus.busy, bus.req_ready); end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = OP_FADD;
        bus.req_a     = 32'd0;
        bus.req_b     = 32'd0;
        bus.req_tag   = 5'd0;
        repeat (5) @(posedge clk);
        test_reset();
        test_fadd();
        test_back_to_back();
        test_int_ops();
        test_sqrt_then_add();
        test_illegal();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire
